z_bitpack: RTL and testbench
============================

Name: z_bitpack

Overview:
- Encoder counterpart of the y-vector unpacker. Reads vector z (L polynomials × N coefficients, stored mod q as 24-bit fields, 4 per 96-bit BRAM word), maps each coefficient to gamma1 − z, and packs the results into COEFF_BIT_LEN-bit fields (FIPS 204 BitPack(z, gamma1−1, gamma1)).
- Emits a little-endian bit stream as DATA_OUT_BITS words over a valid/ready interface to the signature encoder.

Parameters:
- L, 7, number of polynomials in z
- N, 256, coefficients per polynomial
- GAMMA1, 19, gamma1 = 2^GAMMA1
- COEFF_BIT_LEN, GAMMA1+1, packed field width
- COEFF_WIDTH, 24, stored coefficient width
- WORD_LEN, COEFF_WIDTH*4, BRAM word width (4 coefficients)
- DATA_OUT_BITS, 64, output stream word width
- ADDR_POLY_WIDTH, $clog2(L*N*COEFF_WIDTH/WORD_LEN), BRAM address width (9 at defaults)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- start  in  1  begin packing; sampled in IDLE or DONE
- done  out  1  level; high from last word accepted until next start
- addr_vector_z  out  ADDR_POLY_WIDTH  BRAM read address; 1-cycle read latency
- dout_vector_z  in  WORD_LEN  BRAM read data; coefficient k occupies bits [24k +: 24]
- data_out  out  DATA_OUT_BITS  packed stream word; bit 0 = earliest bit
- out_valid  out  1  data_out valid
- out_ready  in  1  consumer accepts data_out
- out_last  out  1  high with the final word
- range_err  out  1  sticky coefficient-range error (see Optional Feature)

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; addr_vector_z=0, data_out=0, out_valid=0, out_last=0, done=0, range_err=0; bit buffer and all counters cleared. Reset mid-operation aborts immediately; no further out_valid.
- States: IDLE → FETCH on start. FETCH drives addr_vector_z → WAIT (1 cycle) → LATCH (register dout_vector_z into word_reg) → PACK. PACK returns to FETCH after consuming 4 coefficients, or goes to DRAIN after the last coefficient (index L*N−1). DRAIN → DONE when the buffer is empty and no word is pending. DONE → FETCH on start, with address and counters reset as from IDLE.
- Coefficient map: c in [0, q), q=8380417. z = c if c <= (q−1)/2, else c − q (signed). Packed value v = gamma1 − z, truncated to COEFF_BIT_LEN bits. Arithmetic must be at least 25-bit signed.
- Bit buffer: width DATA_OUT_BITS+COEFF_BIT_LEN, counter buf_cnt.
  - Insert one coefficient per PACK cycle only when buf_cnt < DATA_OUT_BITS: buf |= v << buf_cnt; buf_cnt += COEFF_BIT_LEN.
  - Move to output when buf_cnt >= DATA_OUT_BITS and (!out_valid || out_ready): data_out <= buf[DATA_OUT_BITS-1:0]; buf >>= DATA_OUT_BITS; out_valid <= 1.
  - Insert and move are mutually exclusive by construction. If PACK cannot insert, it stalls and holds the coefficient index.
- Handshake: a word transfers on out_valid && out_ready. data_out and out_last are held stable while out_valid && !out_ready. out_valid drops the cycle after acceptance if no new word is moved.
- DRAIN: if 0 < buf_cnt < DATA_OUT_BITS, emit the remaining bits zero-padded as the final word. At defaults the total is 7*256*20 = 35840 bits = exactly 560 words, so no pad is needed. out_last is set on the final word.
- Address sequence: 0 .. L*N/4−1 (0..447), incremented once per FETCH; never wraps within a run.
- start is ignored while busy (FETCH/WAIT/LATCH/PACK/DRAIN).

Optional Feature:
- Macro Z_RANGE_CHECK_EN.
- Defined: in PACK, if the signed z lies outside [−gamma1+1, gamma1], range_err is set sticky until reset or the next start. Packing continues with the truncated value.
- Undefined: no check logic is built; range_err is tied to 0.

Test Plan:
- All 1792 coefficients = 0 → 560 words, each packed field = 0x80000; word 0 = 0x0800008000080000; out_last only on word 559; done rises after that word is accepted.
- Coefficients q−1, 524288, 7856130, 1 in word 0 → fields 0x80001, 0x00000, 0xFFFFF, 0x7FFFF; data_out word 0 low 60 bits = 0x7FFFFFFFFF00000_80001 truncated into the 64-bit word per little-endian field order; compare against a software BitPack model.
- out_ready held low 50 cycles after the first out_valid → data_out stable and addr_vector_z frozen once the buffer is full; resumes with no lost or duplicated bits (full stream matches the model).
- rst=0 asserted mid-stream at word 200 → next cycle out_valid=0, done=0; a new start produces a complete correct 560-word stream.
- With Z_RANGE_CHECK_EN, coefficient 600000 (z > gamma1) → range_err=1 stays high to end; without the macro, range_err=0 and the stream is identical.
- start pulsed while in DONE → second run identical to the first; start pulsed during PACK → ignored.

Source files
------------

// File: rtl/z_bitpack_if.sv
// BRAM read port and packed output stream of the z-vector bit packer.
// master: packer side; slave: BRAM model and stream consumer side.
interface z_bitpack_if #(
   parameter int unsigned ADDR_POLY_WIDTH = 9,
   parameter int unsigned WORD_LEN        = 96,
   parameter int unsigned DATA_OUT_BITS   = 64
);
   logic [ADDR_POLY_WIDTH-1:0] addr_vector_z;
   logic [WORD_LEN-1:0]        dout_vector_z;
   logic [DATA_OUT_BITS-1:0]   data_out;
   logic                       out_valid;
   logic                       out_ready;
   logic                       out_last;

   modport master (
      output addr_vector_z,
      input  dout_vector_z,
      output data_out,
      output out_valid,
      input  out_ready,
      output out_last
   );

   modport slave (
      input  addr_vector_z,
      output dout_vector_z,
      input  data_out,
      input  out_valid,
      output out_ready,
      input  out_last
   );
endinterface

// File: rtl/z_bitpack.sv
// Packs z (stored mod q) as gamma1 - z into COEFF_BIT_LEN-bit fields, little-endian stream.
// Optional macro Z_RANGE_CHECK_EN builds a sticky out-of-range flag on range_err.
module z_bitpack #(
   parameter int unsigned L               = 7,
   parameter int unsigned N               = 256,
   parameter int unsigned GAMMA1          = 19,
   parameter int unsigned COEFF_BIT_LEN   = GAMMA1 + 1,
   parameter int unsigned COEFF_WIDTH     = 24,
   parameter int unsigned WORD_LEN        = COEFF_WIDTH * 4,
   parameter int unsigned DATA_OUT_BITS   = 64,
   parameter int unsigned ADDR_POLY_WIDTH = $clog2(L * N * COEFF_WIDTH / WORD_LEN)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         done,
   output logic         range_err,
   z_bitpack_if.master  bus
);

   localparam int unsigned BufW  = DATA_OUT_BITS + COEFF_BIT_LEN;
   localparam int unsigned CntW  = $clog2(BufW + 1);
   localparam int unsigned CoefW = $clog2(L * N + 1);
   localparam int unsigned ZW    = COEFF_WIDTH + 2;

   localparam logic [CntW-1:0]         OutBitsC  = CntW'(DATA_OUT_BITS);
   localparam logic [CntW-1:0]         CoefBitsC = CntW'(COEFF_BIT_LEN);
   localparam logic [CoefW-1:0]        LastCoefC = CoefW'(L * N - 1);
   localparam logic [COEFF_WIDTH-1:0]  HalfQC    = COEFF_WIDTH'((8380417 - 1) / 2);
   localparam logic signed [ZW-1:0]    QC        = ZW'(8380417);
   localparam logic signed [ZW-1:0]    Gamma1C   = ZW'(2 ** GAMMA1);

   typedef enum logic [2:0] {
      StIdle, StFetch, StWait, StLatch, StPack, StDrain, StDone
   } state_e;

   state_e                      state_q, state_d;
   logic [ADDR_POLY_WIDTH-1:0]  addr_q, addr_d;
   logic [WORD_LEN-1:0]         word_q, word_d;
   logic [1:0]                  sub_q, sub_d;
   logic [CoefW-1:0]            coef_q, coef_d;
   logic [BufW-1:0]             bit_buf_q, bit_buf_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic [DATA_OUT_BITS-1:0]    data_q, data_d;
   logic                        valid_q, valid_d;
   logic                        last_q, last_d;

   logic [COEFF_WIDTH-1:0]      coef_raw;
   logic signed [ZW-1:0]        z_val;
   logic [COEFF_BIT_LEN-1:0]    v;
   logic                        can_move;
   logic                        pack_fire;

   // Centred representative of the stored residue, then the packed field gamma1 - z.
   always_comb begin
      coef_raw = word_q[sub_q * COEFF_WIDTH +: COEFF_WIDTH];
      if (coef_raw > HalfQC) begin
         z_val = $signed({2'b00, coef_raw}) - QC;
      end else begin
         z_val = $signed({2'b00, coef_raw});
      end
      v = COEFF_BIT_LEN'(Gamma1C - z_val);
   end

   assign can_move  = !valid_q || bus.out_ready;
   assign pack_fire = (state_q == StPack) && (cnt_q < OutBitsC);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      word_d    = word_q;
      sub_d     = sub_q;
      coef_d    = coef_q;
      bit_buf_d = bit_buf_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;

      if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      // Output move; never coincides with an insert since that needs cnt_q < DATA_OUT_BITS.
      if (cnt_q >= OutBitsC && can_move) begin
         data_d    = bit_buf_q[DATA_OUT_BITS-1:0];
         bit_buf_d = bit_buf_q >> DATA_OUT_BITS;
         cnt_d     = cnt_q - OutBitsC;
         valid_d   = 1'b1;
         last_d    = (state_q == StDrain) && (cnt_q == OutBitsC);
      end else if (state_q == StDrain && cnt_q != '0 && can_move) begin
         data_d    = bit_buf_q[DATA_OUT_BITS-1:0];
         bit_buf_d = '0;
         cnt_d     = '0;
         valid_d   = 1'b1;
         last_d    = 1'b1;
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StFetch;
               addr_d    = '0;
               sub_d     = '0;
               coef_d    = '0;
               bit_buf_d = '0;
               cnt_d     = '0;
               valid_d   = 1'b0;
               last_d    = 1'b0;
            end
         end
         StFetch: state_d = StWait;
         StWait:  state_d = StLatch;
         StLatch: begin
            word_d  = bus.dout_vector_z;
            state_d = StPack;
         end
         StPack: begin
            if (pack_fire) begin
               bit_buf_d = bit_buf_q | (BufW'(v) << cnt_q);
               cnt_d     = cnt_q + CoefBitsC;
               coef_d    = coef_q + CoefW'(1);
               sub_d     = sub_q + 2'd1;
               if (coef_q == LastCoefC) begin
                  state_d = StDrain;
               end else if (sub_q == 2'd3) begin
                  state_d = StFetch;
                  addr_d  = addr_q + ADDR_POLY_WIDTH'(1);
               end
            end
         end
         StDrain: begin
            if (cnt_q == '0 && can_move) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         word_q    <= '0;
         sub_q     <= '0;
         coef_q    <= '0;
         bit_buf_q <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         word_q    <= word_d;
         sub_q     <= sub_d;
         coef_q    <= coef_d;
         bit_buf_q <= bit_buf_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
      end
   end

`ifdef Z_RANGE_CHECK_EN
   localparam logic signed [ZW-1:0] MinZC = ZW'(1) - Gamma1C;

   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((state_q == StIdle || state_q == StDone) && start) begin
         err_d = 1'b0;
      end else if (pack_fire && (z_val > Gamma1C || z_val < MinZC)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign range_err = err_q;
`else
   assign range_err = 1'b0;
`endif

   assign bus.addr_vector_z = addr_q;
   assign bus.data_out      = data_q;
   assign bus.out_valid     = valid_q;
   assign bus.out_last      = last_q;
   assign done              = (state_q == StDone);

endmodule

// File: tb/tb_z_bitpack.sv
// Scoreboard bench for z_bitpack: a bit-list BitPack model fills the expected queue,
// a negedge monitor pops and compares every accepted output word.
module tb_z_bitpack;
   localparam int L      = 7;
   localparam int N      = 256;
   localparam int NW     = L * N / 4;
   localparam int Q      = 8380417;
   localparam int G1     = 1 << 19;
   localparam int FB     = 20;
   localparam int NWORDS = (L * N * FB + 63) / 64;

   typedef struct {
      logic [63:0] data;
      bit          last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic done;
   logic range_err;

   z_bitpack_if bus ();

   z_bitpack dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .done      (done),
      .range_err (range_err),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic [95:0] mem [NW];
   always @(posedge clk) bus.dout_vector_z <= mem[bus.addr_vector_z];

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_words = 0;
   logic [63:0] first_word;
   bit          exp_err;
   int          ready_mode = 0;
   bit          seen = 0;
   int          hold = 0;
   logic [8:0]  frozen_addr;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", name, got, want);
      end
   endtask

   // Reference: z centred mod q, field gamma1 - z, bits appended LSB first, 64-bit chunks.
   task automatic build_expected();
      bit          bits[$];
      exp_t        e;
      logic [95:0] w;
      int          c, z, v, nw;
      exp_q.delete();
      exp_err = 1'b0;
      for (int i = 0; i < L * N; i++) begin
         w = mem[i / 4];
         c = int'(w[(i % 4) * 24 +: 24]);
         z = (c > (Q - 1) / 2) ? c - Q : c;
         if (z > G1 || z < -G1 + 1) exp_err = 1'b1;
         v = G1 - z;
         for (int b = 0; b < FB; b++) bits.push_back(v[b]);
      end
      while (bits.size() % 64 != 0) bits.push_back(1'b0);
      nw = bits.size() / 64;
      for (int k = 0; k < nw; k++) begin
         for (int b = 0; b < 64; b++) e.data[b] = bits[k * 64 + b];
         e.last = (k == nw - 1);
         exp_q.push_back(e);
      end
   endtask

   // kind 0: all zero; 1: random in-range; 2: directed word 0; 3: one out-of-range value.
   task automatic load(input int kind);
      int z, c;
      for (int w = 0; w < NW; w++) begin
         for (int k = 0; k < 4; k++) begin
            if (kind == 0) begin
               c = 0;
            end else begin
               case ($urandom_range(0, 9))
                  0:       z = G1;
                  1:       z = -G1 + 1;
                  2:       z = -1;
                  default: z = int'($urandom_range(0, 2 * G1 - 1)) - (G1 - 1);
               endcase
               c = (z < 0) ? z + Q : z;
            end
            mem[w][k * 24 +: 24] = 24'(c);
         end
      end
      if (kind == 2) mem[0] = {24'd1, 24'd7856130, 24'd524288, 24'(Q - 1)};
      if (kind == 3) mem[5][24 +: 24] = 24'd600000;
   endtask

   task automatic run(input int mode, input int abort_at, input bit poke);
      int cyc;
      bit fin;
      build_expected();
      n_words = 0;
      @(negedge clk);
      ready_mode = mode;
      seen = 1'b0;
      hold = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      fin = 1'b0;
      while (!fin && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         start = poke && (cyc == 20);
         if (abort_at > 0 && n_words >= abort_at) begin
            start = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            check("abort_out_valid", 64'(bus.out_valid), 64'd0);
            check("abort_done", 64'(done), 64'd0);
            rst = 1'b1;
            exp_q.delete();
            return;
         end
         if (done) fin = 1'b1;
      end
      start = 1'b0;
      check("run_finished", 64'(fin), 64'd1);
      check("word_count", 64'(n_words), 64'(NWORDS));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("idle_out_valid", 64'(bus.out_valid), 64'd0);
`ifdef Z_RANGE_CHECK_EN
      check("range_err", 64'(range_err), 64'(exp_err));
`else
      check("range_err", 64'(range_err), 64'd0);
`endif
   endtask

   // Consumer ready: mode 0 always, 1 random, 2 low for 50 cycles after the first valid.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: bus.out_ready = 1'b1;
         1: bus.out_ready = ($urandom_range(0, 3) != 0);
         default: begin
            if (bus.out_valid) seen = 1'b1;
            if (seen && hold < 50) begin
               bus.out_ready = 1'b0;
               hold++;
               if (hold == 30) frozen_addr = bus.addr_vector_z;
               if (hold == 50) check("addr_frozen", 64'(bus.addr_vector_z), 64'(frozen_addr));
            end else begin
               bus.out_ready = 1'b1;
            end
         end
      endcase
   end

   bit          stall = 1'b0;
   logic [63:0] stall_data;
   exp_t        got_e;

   always @(negedge clk) begin
      if (!rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("stall_valid_held", 64'(bus.out_valid), 64'd1);
            check("stall_data_held", bus.data_out, stall_data);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 64'd1, 64'd0);
            end else begin
               got_e = exp_q.pop_front();
               check("data_out", bus.data_out, got_e.data);
               check("out_last", 64'(bus.out_last), 64'(got_e.last));
            end
            if (n_words == 0) first_word = bus.data_out;
            n_words++;
         end
         stall = bus.out_valid && !bus.out_ready;
         stall_data = bus.data_out;
      end
   end

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_last", 64'(bus.out_last), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_range_err", 64'(range_err), 64'd0);
      check("rst_addr", 64'(bus.addr_vector_z), 64'd0);
      check("rst_data_out", bus.data_out, 64'd0);
      rst = 1'b1;

      load(0);
      run(0, 0, 1'b0);
      check("zero_word0", first_word, 64'h0800008000080000);

      load(2);
      run(2, 0, 1'b0);
      check("directed_word0", first_word, 64'hFFFFFF0000080001);

      load(1);
      run(1, 0, 1'b1);
      run(0, 0, 1'b0);

      load(1);
      run(1, 200, 1'b0);
      run(1, 0, 1'b0);

      load(3);
      run(1, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
